// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the accumulator ALU.
//   - 4-bit opcode encodings OP_NOP .. OP_CLR (11..15 are undefined)
//   - FSM state type for the top level (ST_IDLE accepts, ST_MUL waits)
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add multiplier, one partial product per cycle.
//   clock, reset : system clock, asynchronous active-high reset
//   start        : load operands a (multiplicand) and b (multiplier)
//   a, b         : WIDTH-bit unsigned operands
//   done         : high during the cycle whose closing edge adds the last
//                  partial product; product is valid in that same cycle
//   product      : 2*WIDTH-bit unsigned result (valid while done is high)
// start at edge N, partial products added at edges N+1 .. N+WIDTH (LSB of b
// first), so a consumer sampling product when done is high captures it at
// edge N+WIDTH.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] sum;

    always_comb begin
        sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    end

    // The final partial sum is handed out combinationally so the result lands
    // on the same edge as the last iteration.
    assign done    = busy_reg && (cnt_reg == CW'(WIDTH - 1));
    assign product = sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= sum;
            mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_acc.sv
// alu_acc: accumulator ALU with valid/ready issue and registered status.
//   clock, reset       : system clock, asynchronous active-high reset
//   in_valid, in_ready : issue handshake; opcode/data sampled on acceptance
//   opcode, data       : 4-bit operation select and WIDTH-bit operand
//   out_valid          : one-cycle pulse per accepted operation
//   alu_out            : accumulator value after the operation
//   zero, neg          : flags of the new accumulator
//   carry, ovf         : arithmetic flags (held by NOP/undefined opcodes)
//   illegal            : pulses with out_valid for opcodes 11..15
// Single-cycle ops complete on the accepting edge; MUL hands operands to
// alu_mul_seq and completes WIDTH edges later with in_ready low meanwhile.
module alu_acc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    state_t             state_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               illegal_reg;
    logic               zero_reg;
    logic               neg_reg;
    logic               carry_reg;
    logic               ovf_reg;

    logic [WIDTH-1:0]   acc_next;
    logic               carry_next;
    logic               ovf_next;
    logic               illegal_next;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign alu_out   = acc_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;
    assign carry     = carry_reg;
    assign ovf       = ovf_reg;
    assign illegal   = illegal_reg;

    assign mul_start = (state_reg == ST_IDLE) && in_valid && (opcode == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (acc_reg),
        .b       (data),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result. LOAD and the shifts only define the flags they
    // name, so ovf (and carry for LOAD) keep their previous value there.
    always_comb begin
        acc_next     = acc_reg;
        carry_next   = carry_reg;
        ovf_next     = ovf_reg;
        illegal_next = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LOAD: acc_next = data;
            OP_ADD: begin
                {carry_next, acc_next} = {1'b0, acc_reg} + {1'b0, data};
                ovf_next = (acc_reg[MSB] == data[MSB]) && (acc_next[MSB] != acc_reg[MSB]);
            end
            OP_SUB: begin
                acc_next   = acc_reg - data;
                carry_next = (acc_reg >= data);
                ovf_next   = (acc_reg[MSB] != data[MSB]) && (acc_next[MSB] != acc_reg[MSB]);
            end
            OP_AND: begin
                acc_next   = acc_reg & data;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
            OP_OR: begin
                acc_next   = acc_reg | data;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
            OP_XOR: begin
                acc_next   = acc_reg ^ data;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
            OP_SHL: begin
                acc_next   = {acc_reg[MSB-1:0], 1'b0};
                carry_next = acc_reg[MSB];
            end
            OP_SHR: begin
                acc_next   = {1'b0, acc_reg[MSB:1]};
                carry_next = acc_reg[0];
            end
            OP_MUL: ;  // completed through the multiplier path
            OP_CLR: begin
                acc_next   = '0;
                carry_next = 1'b0;
                ovf_next   = 1'b0;
            end
            default: illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            zero_reg      <= 1'b1;
            neg_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            illegal_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (opcode == OP_MUL) begin
                            state_reg    <= ST_MUL;
                            in_ready_reg <= 1'b0;
                        end else begin
                            acc_reg       <= acc_next;
                            carry_reg     <= carry_next;
                            ovf_reg       <= ovf_next;
                            zero_reg      <= (acc_next == '0);
                            neg_reg       <= acc_next[MSB];
                            illegal_reg   <= illegal_next;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        acc_reg       <= mul_product[WIDTH-1:0];
                        carry_reg     <= |mul_product[2*WIDTH-1:WIDTH];
                        ovf_reg       <= 1'b0;
                        zero_reg      <= (mul_product[WIDTH-1:0] == '0);
                        neg_reg       <= mul_product[MSB];
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: self-checking bench for alu_acc at WIDTH = 8 and WIDTH = 16.
module tb_alu_acc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] data = 16'd0;
    logic        in_valid8 = 1'b0;
    logic        in_valid16 = 1'b0;
    logic        sel16 = 1'b0;

    logic        in_ready8, out_valid8, zero8, neg8, carry8, ovf8, illegal8;
    logic [7:0]  alu_out8;
    logic        in_ready16, out_valid16, zero16, neg16, carry16, ovf16, illegal16;
    logic [15:0] alu_out16;

    logic        ready_m, valid_m, zero_m, neg_m, carry_m, ovf_m, illegal_m;
    logic [15:0] out_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_acc #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .opcode(opcode), .data(data[7:0]), .out_valid(out_valid8), .alu_out(alu_out8),
        .zero(zero8), .neg(neg8), .carry(carry8), .ovf(ovf8), .illegal(illegal8)
    );

    alu_acc #(.WIDTH(16)) dut16 (
        .clock(clk), .reset(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .opcode(opcode), .data(data), .out_valid(out_valid16), .alu_out(alu_out16),
        .zero(zero16), .neg(neg16), .carry(carry16), .ovf(ovf16), .illegal(illegal16)
    );

    always_comb begin
        ready_m   = sel16 ? in_ready16  : in_ready8;
        valid_m   = sel16 ? out_valid16 : out_valid8;
        out_m     = sel16 ? alu_out16   : {8'd0, alu_out8};
        zero_m    = sel16 ? zero16      : zero8;
        neg_m     = sel16 ? neg16       : neg8;
        carry_m   = sel16 ? carry16     : carry8;
        ovf_m     = sel16 ? ovf16       : ovf8;
        illegal_m = sel16 ? illegal16   : illegal8;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on the selected DUT and wait for its result. lat counts
    // negedges from acceptance to the one where out_valid is seen; busy
    // counts how many of those had in_ready low.
    task automatic do_op(input logic [3:0] op, input logic [15:0] d,
                         output int lat, output int busy);
        int g;
        @(negedge clk);
        opcode = op;
        data   = d;
        if (sel16) in_valid16 = 1'b1; else in_valid8 = 1'b1;
        g = 0;
        while (!ready_m && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("ready_timeout", 16'd0, 16'd1);
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready_m) busy++;
        end while (!valid_m && lat < 40);
        if (!valid_m) chk("out_valid_timeout", 16'd0, 16'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] d;
        logic [15:0] res;
        logic        c, o, z, n, ill;
        logic        chk_c, chk_o;
    } vec_t;

    vec_t vecs[19];

    // Behavioural model for the 8-bit random run.
    int m_a;
    int m_c, m_o;
    bit c_known, o_known;

    task automatic model(input int op, input int d);
        int s, sa, sd, p;
        sa = (m_a >= 128) ? m_a - 256 : m_a;
        sd = (d >= 128) ? d - 256 : d;
        case (op)
            1: begin m_a = d; c_known = 0; o_known = 0; end
            2: begin
                s = m_a + d; m_c = (s > 255); m_a = s % 256;
                m_o = ((sa + sd) > 127 || (sa + sd) < -128); c_known = 1; o_known = 1;
            end
            3: begin
                m_c = (m_a >= d); m_a = (m_a - d + 256) % 256;
                m_o = ((sa - sd) > 127 || (sa - sd) < -128); c_known = 1; o_known = 1;
            end
            4: begin m_a = m_a & d; m_c = 0; m_o = 0; c_known = 1; o_known = 1; end
            5: begin m_a = m_a | d; m_c = 0; m_o = 0; c_known = 1; o_known = 1; end
            6: begin m_a = m_a ^ d; m_c = 0; m_o = 0; c_known = 1; o_known = 1; end
            7: begin m_c = (m_a >= 128); m_a = (m_a * 2) % 256; c_known = 1; o_known = 0; end
            8: begin m_c = m_a % 2; m_a = m_a / 2; c_known = 1; o_known = 0; end
            9: begin
                p = m_a * d; m_a = p % 256; m_c = (p > 255); m_o = 0;
                c_known = 1; o_known = 1;
            end
            10: begin m_a = 0; m_c = 0; m_o = 0; c_known = 1; o_known = 1; end
            default: ;
        endcase
    endtask

    initial begin
        int lat, busy, cnt, op, d;
        vec_t v;

        vecs[0]  = '{OP_LOAD, 16'h7F, 16'h7F, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{OP_ADD,  16'h01, 16'h80, 0, 1, 0, 1, 0, 1, 1};
        vecs[2]  = '{OP_LOAD, 16'h05, 16'h05, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{OP_SUB,  16'h07, 16'hFE, 0, 0, 0, 1, 0, 1, 1};
        vecs[4]  = '{OP_ADD,  16'h02, 16'h00, 1, 0, 1, 0, 0, 1, 1};
        vecs[5]  = '{OP_LOAD, 16'h0D, 16'h0D, 0, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{OP_MUL,  16'h0B, 16'h8F, 0, 0, 0, 1, 0, 1, 1};
        vecs[7]  = '{OP_MUL,  16'h10, 16'hF0, 1, 0, 0, 1, 0, 1, 1};
        vecs[8]  = '{OP_MUL,  16'h02, 16'hE0, 1, 0, 0, 1, 0, 1, 1};
        vecs[9]  = '{4'd13,   16'h55, 16'hE0, 1, 0, 0, 1, 1, 1, 1};
        vecs[10] = '{OP_AND,  16'h0F, 16'h00, 0, 0, 1, 0, 0, 1, 1};
        vecs[11] = '{OP_OR,   16'h81, 16'h81, 0, 0, 0, 1, 0, 1, 1};
        vecs[12] = '{OP_SHR,  16'h00, 16'h40, 1, 0, 0, 0, 0, 1, 0};
        vecs[13] = '{OP_CLR,  16'h33, 16'h00, 0, 0, 1, 0, 0, 1, 1};
        vecs[14] = '{OP_LOAD, 16'h80, 16'h80, 0, 0, 0, 1, 0, 0, 0};
        vecs[15] = '{OP_SUB,  16'h01, 16'h7F, 1, 1, 0, 0, 0, 1, 1};
        vecs[16] = '{OP_NOP,  16'hAA, 16'h7F, 1, 1, 0, 0, 0, 1, 1};
        vecs[17] = '{OP_SHL,  16'h00, 16'hFE, 0, 0, 0, 1, 0, 1, 0};
        vecs[18] = '{4'd15,   16'h12, 16'hFE, 0, 0, 0, 1, 1, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alu_out", {8'd0, alu_out8}, 16'h00);
        chk("rst_zero", {15'd0, zero8}, 16'd1);
        chk("rst_in_ready", {15'd0, in_ready8}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid8}, 16'd0);
        chk("rst_neg_carry_ovf_ill", {12'd0, neg8, carry8, ovf8, illegal8}, 16'd0);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            do_op(v.op, v.d, lat, busy);
            $display("vec %0d op=%0d d=%0h -> out=%0h c=%0b o=%0b z=%0b n=%0b ill=%0b lat=%0d",
                     i, v.op, v.d, out_m, carry_m, ovf_m, zero_m, neg_m, illegal_m, lat);
            chk($sformatf("vec%0d_out", i), out_m, v.res);
            chk($sformatf("vec%0d_zero", i), {15'd0, zero_m}, {15'd0, v.z});
            chk($sformatf("vec%0d_neg", i), {15'd0, neg_m}, {15'd0, v.n});
            chk($sformatf("vec%0d_illegal", i), {15'd0, illegal_m}, {15'd0, v.ill});
            if (v.chk_c) chk($sformatf("vec%0d_carry", i), {15'd0, carry_m}, {15'd0, v.c});
            if (v.chk_o) chk($sformatf("vec%0d_ovf", i), {15'd0, ovf_m}, {15'd0, v.o});
            chk($sformatf("vec%0d_latency", i), 16'(lat), (v.op == OP_MUL) ? 16'd9 : 16'd1);
            chk($sformatf("vec%0d_busy", i), 16'(busy), (v.op == OP_MUL) ? 16'd8 : 16'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse_end", i), {14'd0, out_valid8, illegal8}, 16'd0);
        end

        // Back-to-back issue with in_valid held high
        @(negedge clk);
        in_valid8 = 1'b1; opcode = OP_LOAD; data = 16'hA5;
        @(negedge clk);
        $display("b2b LOAD -> v=%0b out=%0h", out_valid8, alu_out8);
        chk("b2b_load_valid", {15'd0, out_valid8}, 16'd1);
        chk("b2b_load_out", {8'd0, alu_out8}, 16'hA5);
        opcode = OP_XOR; data = 16'hFF;
        @(negedge clk);
        $display("b2b XOR -> v=%0b out=%0h", out_valid8, alu_out8);
        chk("b2b_xor_valid", {15'd0, out_valid8}, 16'd1);
        chk("b2b_xor_out", {8'd0, alu_out8}, 16'h5A);
        opcode = OP_SHL;
        @(negedge clk);
        $display("b2b SHL -> v=%0b out=%0h c=%0b", out_valid8, alu_out8, carry8);
        chk("b2b_shl_valid", {15'd0, out_valid8}, 16'd1);
        chk("b2b_shl_out", {8'd0, alu_out8}, 16'hB4);
        chk("b2b_shl_carry", {15'd0, carry8}, 16'd0);
        opcode = OP_SHR;
        @(negedge clk);
        $display("b2b SHR -> v=%0b out=%0h c=%0b", out_valid8, alu_out8, carry8);
        chk("b2b_shr_valid", {15'd0, out_valid8}, 16'd1);
        chk("b2b_shr_out", {8'd0, alu_out8}, 16'h5A);
        chk("b2b_shr_carry", {15'd0, carry8}, 16'd0);
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("b2b_idle_valid", {15'd0, out_valid8}, 16'd0);

        // in_valid held during MUL must not be accepted
        do_op(OP_LOAD, 16'h03, lat, busy);
        @(negedge clk);
        in_valid8 = 1'b1; opcode = OP_MUL; data = 16'h05;
        @(posedge clk);
        #1;
        opcode = OP_ADD; data = 16'h01;
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 9) in_valid8 = 1'b0;
            if (out_valid8) begin
                cnt++;
                chk("mulhold_when", 16'(k), 16'd9);
                chk("mulhold_out", {8'd0, alu_out8}, 16'h0F);
            end
        end
        $display("mul-hold: pulses=%0d out=%0h", cnt, alu_out8);
        chk("mulhold_pulses", 16'(cnt), 16'd1);

        // Reset 3 cycles into MUL
        do_op(OP_LOAD, 16'h09, lat, busy);
        @(negedge clk);
        in_valid8 = 1'b1; opcode = OP_MUL; data = 16'h07;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid8) cnt++;
        end
        $display("mul-abort: pulses=%0d out=%0h ready=%0b", cnt, alu_out8, in_ready8);
        chk("abort_pulses", 16'(cnt), 16'd0);
        chk("abort_out", {8'd0, alu_out8}, 16'h00);
        chk("abort_zero", {15'd0, zero8}, 16'd1);
        chk("abort_ready", {15'd0, in_ready8}, 16'd1);

        // Randomized run against the model, starting from a known state
        m_a = 0; m_c = 0; m_o = 0; c_known = 0; o_known = 0;
        for (int i = 0; i < 150; i++) begin
            if (i == 0) op = 10; else op = $urandom_range(0, 15);
            d = $urandom_range(0, 255);
            do_op(4'(op), 16'(d), lat, busy);
            model(op, d);
            $display("rnd %0d op=%0d d=%0h -> out=%0h c=%0b o=%0b (model %0h c=%0d o=%0d)",
                     i, op, d, out_m, carry_m, ovf_m, m_a, m_c, m_o);
            chk("rnd_out", out_m, 16'(m_a));
            chk("rnd_zero", {15'd0, zero_m}, (m_a == 0) ? 16'd1 : 16'd0);
            chk("rnd_neg", {15'd0, neg_m}, (m_a >= 128) ? 16'd1 : 16'd0);
            chk("rnd_illegal", {15'd0, illegal_m}, (op > 10) ? 16'd1 : 16'd0);
            if (c_known) chk("rnd_carry", {15'd0, carry_m}, 16'(m_c));
            if (o_known) chk("rnd_ovf", {15'd0, ovf_m}, 16'(m_o));
            chk("rnd_latency", 16'(lat), (op == 9) ? 16'd9 : 16'd1);
        end

        // WIDTH = 16 instance
        sel16 = 1'b1;
        do_op(OP_LOAD, 16'hFFFF, lat, busy);
        chk("w16_load", out_m, 16'hFFFF);
        do_op(OP_ADD, 16'h0001, lat, busy);
        $display("w16 ADD -> out=%0h c=%0b z=%0b o=%0b", out_m, carry_m, zero_m, ovf_m);
        chk("w16_add_out", out_m, 16'h0000);
        chk("w16_add_carry", {15'd0, carry_m}, 16'd1);
        chk("w16_add_zero", {15'd0, zero_m}, 16'd1);
        chk("w16_add_ovf", {15'd0, ovf_m}, 16'd0);
        do_op(OP_LOAD, 16'h0123, lat, busy);
        do_op(OP_MUL, 16'h0045, lat, busy);
        $display("w16 MUL -> out=%0h c=%0b lat=%0d busy=%0d", out_m, carry_m, lat, busy);
        chk("w16_mul_out", out_m, 16'h4E6F);
        chk("w16_mul_carry", {15'd0, carry_m}, 16'd0);
        chk("w16_mul_latency", 16'(lat), 16'd17);
        chk("w16_mul_busy", 16'(busy), 16'd16);
        do_op(OP_MUL, 16'h0100, lat, busy);
        $display("w16 MUL -> out=%0h c=%0b", out_m, carry_m);
        chk("w16_mul2_out", out_m, 16'h6F00);
        chk("w16_mul2_carry", {15'd0, carry_m}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
